// File: rtl/d_ff_pipe.sv
// ============================================================================
// Module   : d_ff_pipe
// Purpose  : Enabled, flushable D flip-flop pipeline with per-stage valid bits,
//            a running valid count and a selectable observation tap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_ff_pipe #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int                CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_tap_q;
    logic             w_tap_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= RESET_VAL;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= RESET_VAL;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (en) begin
            r_data[0]  <= d;
            r_valid[0] <= d_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
            // Entering valid adds one, leaving valid removes one; stays equal to popcount.
            r_count <= r_count + CNT_W'(d_valid) - CNT_W'(r_valid[DEPTH-1]);
        end
    end

    // Out-of-range selects fall through to the reset value with valid low.
    always_comb begin
        w_tap_q     = RESET_VAL;
        w_tap_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_sel == TAP_W'(k)) begin
                w_tap_q     = r_data[k];
                w_tap_valid = r_valid[k];
            end
        end
    end

    assign q         = r_data[DEPTH-1];
    assign q_valid   = r_valid[DEPTH-1];
    assign tap_q     = w_tap_q;
    assign tap_valid = w_tap_valid;
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_d_ff_pipe.sv
// ============================================================================
// Module   : tb_d_ff_pipe
// Purpose  : Self-checking bench for d_ff_pipe (DEPTH=4 and DEPTH=3 instances)
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_ff_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] d = 8'h00;
    logic       d_valid = 1'b0;
    logic [1:0] tap_sel = 2'd0;

    logic [7:0] q4, tap_q4, q3, tap_q3;
    logic       q_valid4, tap_valid4, q_valid3, tap_valid3;
    logic [2:0] count4;
    logic [1:0] count3;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Model: index 0 is stage 0; each entry is {valid, data}.
    logic [8:0] m4[$];
    logic [8:0] m3[$];

    d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(tap_sel), .q(q4), .q_valid(q_valid4), .tap_q(tap_q4),
        .tap_valid(tap_valid4), .count(count4)
    );

    d_ff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(tap_sel), .q(q3), .q_valid(q_valid3), .tap_q(tap_q3),
        .tap_valid(tap_valid3), .count(count3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m4 = '{9'h0, 9'h0, 9'h0, 9'h0};
        m3 = '{9'h0, 9'h0, 9'h0};
    endtask

    // Advance one clock edge and apply the pipeline rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                model_clear();
            end else if (en) begin
                m4.push_front({d_valid, d});
                void'(m4.pop_back());
                m3.push_front({d_valid, d});
                void'(m3.pop_back());
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        int       c4, c3;
        logic [8:0] t3;
        c4 = 0;
        c3 = 0;
        foreach (m4[i]) c4 += int'(m4[i][8]);
        foreach (m3[i]) c3 += int'(m3[i][8]);
        t3 = (tap_sel < 2'd3) ? m3[tap_sel] : 9'h000;
        chk({tag, "_q4"},    {24'h0, q4},         {24'h0, m4[3][7:0]});
        chk({tag, "_qv4"},   {31'h0, q_valid4},   {31'h0, m4[3][8]});
        chk({tag, "_cnt4"},  {29'h0, count4},     32'(c4));
        chk({tag, "_tap4"},  {23'h0, tap_valid4, tap_q4}, {23'h0, m4[tap_sel]});
        chk({tag, "_q3"},    {23'h0, q_valid3, q3}, {23'h0, m3[2]});
        chk({tag, "_cnt3"},  {30'h0, count3},     32'(c3));
        chk({tag, "_tap3"},  {23'h0, tap_valid3, tap_q3}, {23'h0, t3});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all("rst");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held across an edge with active-looking inputs.
        en = 1'b1; d_valid = 1'b1; d = 8'hFF; flush = 1'b0;
        model_clear();
        tick();
        check_all("por");
        chk("por_q", {24'h0, q4}, 32'h0);
        rst_n = 1'b1;
        #2;

        // Fill
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'h11 * (i + 1));
            tick();
            chk("fill_cnt", {29'h0, count4}, 32'((i < 4) ? i + 1 : 4));
            check_all("fill");
            if (i == 3) chk("fill_q_e4", {23'h0, q_valid4, q4}, 32'h111);
            if (i == 4) chk("fill_q_e5", {24'h0, q4}, 32'h22);
        end

        // Stall
        do_reset();
        d = 8'h11; tick();
        d = 8'h22; tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = 8'(8'hC0 + i);
            tap_sel = 2'(i);
            tick();
            check_all("stall");
            chk("stall_cnt", {29'h0, count4}, 32'd2);
        end
        en = 1'b1;
        d = 8'h33; tick();
        d = 8'h44; tick();
        chk("stall_resume_q", {23'h0, q_valid4, q4}, 32'h111);
        check_all("resume");

        // Flush wins over en
        flush = 1'b1; d = 8'h99; tick();
        check_all("flush");
        chk("flush_cnt", {29'h0, count4}, 32'd0);
        flush = 1'b0; d = 8'hAA; tap_sel = 2'd0; tick();
        chk("flush_next_tap0", {23'h0, tap_valid4, tap_q4}, 32'h1AA);
        check_all("post_flush");

        // Bubbles
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = 8'(i + 1);
            d_valid = (i < 4) ? ((i % 2) == 0) : 1'b0;
            tick();
            check_all("bubble");
            chk("bubble_cnt_le2", {31'h0, count4 <= 3'd2}, 32'd1);
            if (i >= 3 && i <= 6)
                chk("bubble_q", {23'h0, q_valid4, q4}, {23'h0, ((i % 2) == 1), 8'(i - 2)});
        end

        // Tap sweep with stages 0x44,0x33,0x22,0x11
        do_reset();
        d_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h11 * (i + 1));
            tick();
        end
        en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tap_sel = 2'(s);
            #1;
            chk("tap_sweep4", {24'h0, tap_q4}, 32'(8'h44 - 8'h11 * s));
            chk("tap_sweep3", {23'h0, tap_valid3, tap_q3}, (s < 3) ? 32'(9'h144 - 9'h011 * s) : 32'h0);
        end

        // Async reset between edges with a full pipe
        en = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_q", {22'h0, count4, q_valid4, q4}, 32'h0);
        check_all("async");
        #1;
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            d_valid = 1'($urandom);
            d       = 8'($urandom);
            tap_sel = 2'($urandom);
            tick();
            check_all("rand");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
